// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned N x N multiplier: one shift-add step per clock through a shared
// carry-increment adder, with a start strobe, busy flag and one-cycle done pulse.

module carry_increment_adder #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         OF
);
   localparam int unsigned Blocks = N / 4;

   logic [4:0] raw;
   logic [4:0] inc;
   logic       carry;

   // Each 4-bit block adds with carry-in 0, then increments when the incoming carry is set.
   always_comb begin
      raw   = '0;
      inc   = '0;
      carry = cin;
      sum   = '0;
      for (int b = 0; b < Blocks; b++) begin
         raw = {1'b0, in1[4*b +: 4]} + {1'b0, in2[4*b +: 4]};
         inc = {1'b0, raw[3:0]} + {4'b0000, carry};
         sum[4*b +: 4] = inc[3:0];
         carry = raw[4] | inc[4];
      end
      cout = carry;
   end

   assign OF = (in1[N-1] == in2[N-1]) && (sum[N-1] != in1[N-1]);
endmodule

module seq_shift_add_multiplier #(
   parameter int unsigned N = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   in1,
   input  logic [N-1:0]   in2,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);
   localparam int unsigned CntW = $clog2(N);
   localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q;
   logic [N-1:0]    m_q;
   logic [N-1:0]    a_q;
   logic [N-1:0]    q_q;
   logic [CntW-1:0] cnt_q;
   logic [2*N-1:0]  product_q;

   logic [N-1:0]    addend;
   logic [N-1:0]    sum;
   logic            cout;
   logic            adder_of_unused;

   assign addend = q_q[0] ? m_q : '0;

   carry_increment_adder #(
      .N (N)
   ) u_adder (
      .in1  (a_q),
      .in2  (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout),
      .OF   (adder_of_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         m_q       <= '0;
         a_q       <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (in1 == '0 || in2 == '0) begin
                     product_q <= '0;
                     state_q   <= StDone;
                  end else begin
                     m_q     <= in1;
                     a_q     <= '0;
                     q_q     <= in2;
                     cnt_q   <= '0;
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               a_q   <= {cout, sum[N-1:1]};
               q_q   <= {sum[0], q_q[N-1:1]};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  // Post-shift value of {A, Q} after the final step.
                  product_q <= {cout, sum, q_q[N-1:1]};
                  state_q   <= StDone;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy    = (state_q == StRun);
   assign done    = (state_q == StDone);
   assign product = product_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier at N=32 and N=8, using a vector table,
// hand-written corner sequences and a randomized sweep against a '*' reference model.

module tb_seq_shift_add_multiplier;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        s32 = 1'b0;
   logic [31:0] a32 = '0;
   logic [31:0] b32 = '0;
   logic        busy32;
   logic        done32;
   logic [63:0] p32;

   logic        s8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        busy8;
   logic        done8;
   logic [15:0] p8;

   int tests = 0;
   int fails = 0;

   seq_shift_add_multiplier #(.N(32)) dut32 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (s32),
      .in1     (a32),
      .in2     (b32),
      .busy    (busy32),
      .done    (done32),
      .product (p32)
   );

   seq_shift_add_multiplier #(.N(8)) dut8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (s8),
      .in1     (a8),
      .in2     (b8),
      .busy    (busy8),
      .done    (done8),
      .product (p8)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] expv;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic cur_done(input bit sel);
      return sel ? done8 : done32;
   endfunction

   function automatic logic cur_busy(input bit sel);
      return sel ? busy8 : busy32;
   endfunction

   function automatic logic [63:0] cur_prod(input bit sel);
      return sel ? {48'd0, p8} : p32;
   endfunction

   // One full transaction: start at edge 0, then check latency, busy span, product, done width.
   task automatic mul(input bit sel, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] expv, input string name);
      int          width;
      int          cycles;
      int          busy_cnt;
      int          exp_lat;
      logic [31:0] ea;
      logic [31:0] eb;
      width = sel ? 8 : 32;
      ea    = sel ? {24'd0, a[7:0]} : a;
      eb    = sel ? {24'd0, b[7:0]} : b;
      exp_lat = (ea == 0 || eb == 0) ? 0 : width;
      @(negedge clk);
      if (sel) begin s8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
      else begin s32 = 1'b1; a32 = a; b32 = b; end
      @(posedge clk);
      @(negedge clk);
      // Operands are free to change once sampled.
      if (sel) begin s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
      else begin s32 = 1'b0; a32 = $urandom; b32 = $urandom; end
      cycles = 0;
      busy_cnt = 0;
      while (!cur_done(sel) && cycles < width + 10) begin
         if (cur_busy(sel)) busy_cnt++;
         @(negedge clk);
         cycles++;
      end
      check({name, " latency"}, 64'(cycles), 64'(exp_lat));
      check({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
      check({name, " product"}, cur_prod(sel), expv);
      @(negedge clk);
      check({name, " done pulse/hold"}, {cur_done(sel), cur_busy(sel), cur_prod(sel)},
            {1'b0, 1'b0, expv});
   endtask

   vec_t vecs[6];

   initial begin
      int          cycles;
      int          dones;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0] = '{a: 32'd3,          b: 32'd5,          expv: 64'h0000_0000_0000_000F};
      vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  expv: 64'hFFFF_FFFE_0000_0001};
      vecs[2] = '{a: 32'd0,          b: 32'h1234,       expv: 64'd0};
      vecs[3] = '{a: 32'h5555,       b: 32'd0,          expv: 64'd0};
      vecs[4] = '{a: 32'h10,         b: 32'h10,         expv: 64'h100};
      vecs[5] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  expv: 64'h4000_0000_0000_0000};

      #12;
      check("reset state n32", {busy32, done32, p32}, 66'd0);
      check("reset state n8", {busy8, done8, 48'd0, p8}, 66'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) mul(1'b0, vecs[i].a, vecs[i].b, vecs[i].expv, $sformatf("vec%0d", i));

      // Start pulsed during RUN is dropped; start held high is taken at edge N+2.
      @(negedge clk);
      s32 = 1'b1; a32 = 32'h10; b32 = 32'h10;
      @(posedge clk);
      @(negedge clk);
      s32 = 1'b0;
      cycles = 0;
      dones = 0;
      while (!done32 && cycles < 45) begin
         if (cycles == 4) begin s32 = 1'b1; a32 = 32'd7; b32 = 32'd9; end
         if (cycles == 5) s32 = 1'b0;
         @(negedge clk);
         cycles++;
      end
      check("ignored start latency", 64'(cycles), 64'd32);
      check("ignored start product", p32, 64'h100);
      s32 = 1'b1; a32 = 32'd7; b32 = 32'd9;
      cycles = 0;
      @(negedge clk);
      cycles++;
      while (!done32 && cycles < 50) begin
         if (done32) dones++;
         @(negedge clk);
         cycles++;
      end
      s32 = 1'b0;
      check("held start latency", 64'(cycles), 64'd34);
      check("held start product", p32, 64'h3F);
      @(negedge clk);
      @(negedge clk);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      s32 = 1'b1; a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      s32 = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid-run reset outputs", {busy32, done32, p32}, 66'd0);
      dones = 0;
      repeat (3) begin
         @(negedge clk);
         if (done32) dones++;
      end
      check("no done during reset", 64'(dones), 64'd0);
      #2;
      rst_n = 1'b1;
      mul(1'b0, 32'hDEAD_BEEF, 32'h1234_5678,
          64'(32'hDEAD_BEEF) * 64'(32'h1234_5678), "after reset");

      mul(1'b1, 32'hFF, 32'hFF, 64'hFE01, "n8 max");
      mul(1'b1, 32'h00, 32'h3C, 64'h0, "n8 zero");

      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         mul(1'b0, ra, rb, 64'(ra) * 64'(rb), $sformatf("rand32_%0d", i));
      end
      for (int i = 0; i < 1000; i++) begin
         ra = {24'd0, 8'($urandom)};
         rb = {24'd0, 8'($urandom)};
         mul(1'b1, ra, rb, 64'(ra) * 64'(rb), $sformatf("rand8_%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
